// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: reset PC, NOP encoding, jump opcodes and the IF/ID record.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [5:0]  OP_J          = 6'b000010;
  localparam logic [5:0]  OP_JAL        = 6'b000011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
  } ifid_t;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_JUMP,
    NPC_BRANCH
  } npc_sel_e;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  Clk,
  input  logic  Reset,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush_i)     ifid_d = '{instr: NOP_INSTR, pc4: 32'h0, vld: 1'b0};
    else if (load_i) ifid_d = d_i;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) ifid_q <= '{instr: NOP_INSTR, pc4: 32'h0, vld: 1'b0};
    else       ifid_q <= ifid_d;
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, IF/ID register and fetch counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  output logic [31:0] InstrAddr,
  input  logic [31:0] InstrData,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] cnt_q, cnt_d;
  npc_sel_e    npc_sel;
  logic        redirect, load;
  ifid_t       ifid_d, ifid_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = BranchTaken | Jump;
  assign load     = ~redirect & ~Stall;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (BranchTaken) npc_sel = NPC_BRANCH;
    else if (Jump)   npc_sel = NPC_JUMP;
    else if (Stall)  npc_sel = NPC_HOLD;
  end

  // Jump region comes from the jump's own PC+4, which sits in IF/ID.
  always_comb begin
    pc_d = pc_plus4;
    unique case (npc_sel)
      NPC_BRANCH: pc_d = {BranchTarget[31:2], 2'b00};
      NPC_JUMP:   pc_d = {ifid_q.pc4[31:28], JumpIndex, 2'b00};
      NPC_HOLD:   pc_d = pc_q;
      default:    pc_d = pc_plus4;
    endcase
  end

  assign cnt_d = load ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign ifid_d = '{instr: InstrData, pc4: pc_plus4, vld: 1'b1};

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .Clk     (Clk),
    .Reset   (Reset),
    .load_i  (load),
    .flush_i (redirect),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign InstrAddr        = pc_q;
  assign IFID_Instruction = ifid_q.instr;
  assign IFID_PCPlus4     = ifid_q.pc4;
  assign IFID_Valid       = ifid_q.vld;
  assign FetchCount       = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random checks of fetch_stage against a cycle-level model of the fetch rules.
module tb_fetch_stage;

  logic        Clk, Reset, Stall, BranchTaken, Jump;
  logic [31:0] BranchTarget;
  logic [25:0] JumpIndex;
  logic [31:0] InstrAddr, InstrData, IFID_Instruction, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid;

  logic [31:0] w_addr, w_data, w_instr, w_pc4, w_cnt;
  logic        w_vld;

  int n_chk = 0, n_fail = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_vld;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h1000;
  endfunction

  assign InstrData = mem(InstrAddr);
  assign w_data    = mem(w_addr);

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpIndex(JumpIndex),
    .InstrAddr(InstrAddr), .InstrData(InstrData),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .FetchCount(FetchCount)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .Clk(Clk), .Reset(Reset), .Stall(1'b0), .BranchTaken(1'b0),
    .BranchTarget(32'h0), .Jump(1'b0), .JumpIndex(26'h0),
    .InstrAddr(w_addr), .InstrData(w_data),
    .IFID_Instruction(w_instr), .IFID_PCPlus4(w_pc4),
    .IFID_Valid(w_vld), .FetchCount(w_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_pc"},    InstrAddr,        m_pc);
    chk({tag, "_instr"}, IFID_Instruction, m_instr);
    chk({tag, "_pc4"},   IFID_PCPlus4,     m_pc4);
    chk({tag, "_vld"},   {31'h0, IFID_Valid}, {31'h0, m_vld});
    chk({tag, "_cnt"},   FetchCount,       m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_cnt = 32'h0;
  endtask

  // Drive one cycle's controls, advance the model over the edge, check #1 after it.
  task automatic cyc(input string tag, input logic st, input logic br,
                     input logic [31:0] bt, input logic j, input logic [25:0] ji);
    logic [31:0] npc;
    Stall = st; BranchTaken = br; BranchTarget = bt; Jump = j; JumpIndex = ji;
    if (br)      npc = {bt[31:2], 2'b00};
    else if (j)  npc = {m_pc4[31:28], ji, 2'b00};
    else if (st) npc = m_pc;
    else         npc = m_pc + 32'd4;
    @(posedge Clk); #1;
    if (br || j) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
    end else if (!st) begin
      m_instr = mem(m_pc); m_pc4 = m_pc + 32'd4; m_vld = 1'b1; m_cnt = m_cnt + 32'd1;
    end
    m_pc = npc;
    chk_all(tag);
  endtask

  // Reset raised mid-cycle, held across an edge with hazards asserted, released away from the edge.
  task automatic async_reset(input string tag);
    #2 Reset = 1'b1;
    model_reset();
    #1 chk_all({tag, "_async"});
    Stall = 1'b1; Jump = 1'b1; JumpIndex = 26'h3FF_FFFF; BranchTaken = 1'b1; BranchTarget = 32'h400;
    @(posedge Clk); #1;
    chk_all({tag, "_held"});
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Stall = 0; BranchTaken = 0; BranchTarget = 0; Jump = 0; JumpIndex = 0;
    model_reset();
    @(posedge Clk); #1;
    chk_all("rst");
    chk("wrap_rst_pc", w_addr, 32'hFFFF_FFFC);
    Reset = 1'b0;

    // plain sequential fetch, plus the wrap instance
    cyc("seq1", 0, 0, 0, 0, 0);
    chk("wrap1_pc", w_addr, 32'h0);
    chk("wrap1_pc4", w_pc4, 32'h0);
    chk("wrap1_instr", w_instr, 32'h0000_0FFC);
    chk("wrap1_vld", {31'h0, w_vld}, 32'h1);
    cyc("seq2", 0, 0, 0, 0, 0);
    chk("wrap2_pc4", w_pc4, 32'h4);
    cyc("seq3", 0, 0, 0, 0, 0);
    chk("seq3_addr", InstrAddr, 32'hC);
    chk("seq3_cnt", FetchCount, 32'd3);
    cyc("seq4", 0, 0, 0, 0, 0);

    // stall three cycles at PC 0x10
    for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 0, 0, 0);
    chk("stall_pc", InstrAddr, 32'h10);
    chk("stall_instr", IFID_Instruction, 32'h100C);
    chk("stall_cnt", FetchCount, 32'd4);
    cyc("resume", 0, 0, 0, 0, 0);
    chk("resume_pc", InstrAddr, 32'h14);

    // branch overrides stall, target low bits dropped
    cyc("br", 1, 1, 32'h203, 0, 0);
    chk("br_pc", InstrAddr, 32'h200);
    chk("br_instr", IFID_Instruction, 32'h0);
    cyc("br_tgt", 0, 0, 0, 0, 0);
    chk("br_tgt_instr", IFID_Instruction, 32'h1200);

    // async reset mid-operation, then jump from IFID_PCPlus4 = 8
    async_reset("mid");
    cyc("rs1", 0, 0, 0, 0, 0);
    cyc("rs2", 0, 0, 0, 0, 0);
    chk("rs2_pc4", IFID_PCPlus4, 32'h8);
    cyc("jmp", 0, 0, 0, 1, 26'h0000040);
    chk("jmp_pc", InstrAddr, 32'h100);
    cyc("jmp_tgt", 0, 0, 0, 0, 0);
    cyc("br_jmp", 0, 1, 32'h300, 1, 26'h0000040);
    chk("br_jmp_pc", InstrAddr, 32'h300);

    // random mix
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) async_reset("rnd");
      else cyc("rnd", $urandom_range(99) < 25, $urandom_range(99) < 10, $urandom,
               $urandom_range(99) < 10, 26'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, presents the fetch address to instruction memory, computes PC+4, applies branch/jump redirects and stalls, and drives the IF/ID pipeline register consumed by the decode stage (controller, register file, sign extension). It replaces the externally driven instruction address in the current top level. The block gives the pipeline a single clocked source of fetched instructions, including flush and stall handling.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000: instruction injected into IF/ID on reset or flush (sll $0,$0,0).

Ports:
- Clk  input  1  pipeline clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hazard-unit request to hold PC and IF/ID.
- BranchTaken  input  1  taken branch resolved in EX/MEM.
- BranchTarget  input  32  branch target address from EX/MEM.
- Jump  input  1  jump decoded in ID this cycle.
- JumpIndex  input  26  instr[25:0] of the jump in ID.
- InstrAddr  output  32  current PC, to instruction memory.
- InstrData  input  32  instruction memory read data, combinational from InstrAddr.
- IFID_Instruction  output  32  registered instruction to decode.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- FetchCount  output  32  count of valid instructions loaded into IF/ID.

## Operation

- PC register. InstrAddr is the PC. PCPlus4 = PC + 4, modulo 2^32.
- Next PC priority, highest first:
  1. BranchTaken: {BranchTarget[31:2],2'b00}.
  2. Jump: {IFID_PCPlus4[31:28], JumpIndex, 2'b00}.
  3. Stall: PC held.
  4. Otherwise PCPlus4.
- IF/ID update:
  - If BranchTaken or Jump: flush. Instruction = NOP_INSTR, PCPlus4 = 0, Valid = 0.
  - Else if Stall: hold all IF/ID fields.
  - Else: load InstrData and PCPlus4, with Valid = 1.
- A redirect overrides Stall. The redirecting instruction is older than the stalled one, so the stalled instruction is discarded.
- FetchCount increments by 1 on each edge where IF/ID loads with Valid = 1. It wraps from 32'hFFFF_FFFF to 0.
- Reset, whether at power-up or mid-operation, forces immediately and asynchronously:
  - PC = RESET_PC.
  - IF/ID = NOP_INSTR / 0 / Valid 0.
  - FetchCount = 0.
- Stall, BranchTaken and Jump are ignored while Reset is high.

## Timing

- Fetch latency is 1 cycle: an instruction at address A appears on IFID_Instruction one edge after InstrAddr = A.
- After Reset deasserts:
  - The first edge loads IF/ID from RESET_PC (Valid = 1) and moves the PC to RESET_PC + 4.
  - IFID_Valid is 0 until that first edge.
- Branch penalty, from the EX/MEM signal: the redirect edge loads BranchTarget into the PC and flushes IF/ID. The target instruction reaches IF/ID on the next edge. Instructions already in ID and EX are not flushed by this block.
- Jump penalty is one bubble: the slot after the jump is flushed and the target reaches IF/ID two edges after the jump entered ID.
- With Stall held for N cycles, PC and IF/ID are constant for N edges and FetchCount does not change.
- No combinational path exists from Stall, BranchTaken or Jump to the IF/ID outputs. Those outputs are registered only.

## Structure

- Shared pipeline package holds RESET_PC default, NOP_INSTR encoding, and the J/JAL opcodes (6'b000010, 6'b000011) used by the controller to produce Jump.
- One sub-module: if_id_reg. It holds the Instruction, PCPlus4 and Valid registers, with load, hold and flush controls and async reset. It is instantiated once in fetch_stage.
- Next-PC mux and FetchCount stay in fetch_stage.

## Test plan

1. Reset release, no stall, memory word at address A = A + 32'h1000:
   - InstrAddr steps 0, 4, 8 on successive edges.
   - IFID_Instruction = 32'h1000, 32'h1004, … with IFID_PCPlus4 = 4, 8, ….
   - FetchCount = 1, 2, 3.
2. Stall for 3 cycles at PC = 0x10: PC stays 0x10, IF/ID holds the 0x0C instruction with PCPlus4 = 0x10, and FetchCount stays frozen. Fetch resumes at 0x14.
3. BranchTaken with BranchTarget = 0x203 and Stall = 1 in the same cycle:
   - The next PC is 0x200.
   - IFID_Valid = 0 and IFID_Instruction = NOP_INSTR.
   - One edge later, IF/ID holds the 0x200 instruction.
4. Jump = 1 with JumpIndex = 26'h0000040 and IFID_PCPlus4 = 0x0000_0008: the next PC is 0x100 and IF/ID is flushed. BranchTaken asserted together with this jump wins.
5. Set RESET_PC = 32'hFFFF_FFFC and run 2 cycles: PC wraps to 0, and IFID_PCPlus4 = 0 on the first loaded instruction.
6. Assert Reset asynchronously mid-cycle during steady fetch: PC, IF/ID and FetchCount clear before the next edge, and fetch restarts from RESET_PC after release.
